// File: rtl/pic_fetch.sv
// Instruction-fetch stage: owns the PC, drives the combinational program ROM,
// captures the returned word into the IR and keeps a 2-entry return stack.
// Redirects from execute (ret > call > jump > skip) flush the IR with a bubble.
module pic_fetch #(
    parameter int unsigned              ADDR_W       = 9,
    parameter int unsigned              DATA_W       = 12,
    parameter logic [DATA_W-1:0]        NOP_WORD     = '0,
    parameter logic [ADDR_W-1:0]        RESET_VECTOR = '0
) (
    input  logic              i_clk,
    input  logic              i_rst,
    output logic [ADDR_W-1:0] o_rom_addr,
    input  logic [DATA_W-1:0] i_rom_data,
    input  logic              i_stall,
    input  logic              i_jump_en,
    input  logic              i_call_en,
    input  logic              i_ret_en,
    input  logic              i_skip,
    input  logic [ADDR_W-1:0] i_jump_addr,
    output logic [DATA_W-1:0] o_ir,
    output logic              o_ir_valid,
    output logic [ADDR_W-1:0] o_ir_pc,
    output logic              o_stack_ovf,
    output logic              o_stack_unf
);

    logic [ADDR_W-1:0] r_pc;
    logic [DATA_W-1:0] r_ir;
    logic              r_ir_valid;
    logic [ADDR_W-1:0] r_ir_pc;
    logic [ADDR_W-1:0] r_stack0;
    logic [ADDR_W-1:0] r_stack1;
    logic [1:0]        r_depth;
    logic              r_ovf;
    logic              r_unf;

    logic [ADDR_W-1:0] w_pc_nxt;
    logic [DATA_W-1:0] w_ir_nxt;
    logic              w_ir_valid_nxt;
    logic [ADDR_W-1:0] w_ir_pc_nxt;
    logic [ADDR_W-1:0] w_stack0_nxt;
    logic [ADDR_W-1:0] w_stack1_nxt;
    logic [1:0]        w_depth_nxt;
    logic              w_ovf_nxt;
    logic              w_unf_nxt;
    logic [ADDR_W-1:0] w_pc_inc;

    // PC wraps naturally modulo 2^ADDR_W.
    assign w_pc_inc   = r_pc + ADDR_W'(1);
    assign o_rom_addr = r_pc;

    // Next-state selection: one action per unstalled edge, ret > call > jump > skip > sequential.
    always_comb begin
        w_pc_nxt       = r_pc;
        w_ir_nxt       = r_ir;
        w_ir_valid_nxt = r_ir_valid;
        w_ir_pc_nxt    = r_ir_pc;
        w_stack0_nxt   = r_stack0;
        w_stack1_nxt   = r_stack1;
        w_depth_nxt    = r_depth;
        w_ovf_nxt      = r_ovf;
        w_unf_nxt      = r_unf;
        if (!i_stall) begin
            if (i_ret_en) begin
                // Pop; stack1 is duplicated into stack0. Underflow still loads stack0.
                w_pc_nxt       = r_stack0;
                w_stack0_nxt   = r_stack1;
                if (r_depth == 2'd0) begin
                    w_unf_nxt = 1'b1;
                end else begin
                    w_depth_nxt = r_depth - 2'd1;
                end
                w_ir_nxt       = NOP_WORD;
                w_ir_valid_nxt = 1'b0;
            end else if (i_call_en) begin
                // Push the not-yet-executed PC as return address; oldest entry drops on overflow.
                w_pc_nxt       = i_jump_addr;
                w_stack1_nxt   = r_stack0;
                w_stack0_nxt   = r_pc;
                if (r_depth == 2'd2) begin
                    w_ovf_nxt = 1'b1;
                end else begin
                    w_depth_nxt = r_depth + 2'd1;
                end
                w_ir_nxt       = NOP_WORD;
                w_ir_valid_nxt = 1'b0;
            end else if (i_jump_en) begin
                w_pc_nxt       = i_jump_addr;
                w_ir_nxt       = NOP_WORD;
                w_ir_valid_nxt = 1'b0;
            end else if (i_skip) begin
                // Squash the word at pc but keep fetching sequentially.
                w_pc_nxt       = w_pc_inc;
                w_ir_nxt       = NOP_WORD;
                w_ir_valid_nxt = 1'b0;
                w_ir_pc_nxt    = r_pc;
            end else begin
                w_pc_nxt       = w_pc_inc;
                w_ir_nxt       = i_rom_data;
                w_ir_valid_nxt = 1'b1;
                w_ir_pc_nxt    = r_pc;
            end
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pc       <= RESET_VECTOR;
            r_ir       <= NOP_WORD;
            r_ir_valid <= 1'b0;
            r_ir_pc    <= '0;
            r_stack0   <= '0;
            r_stack1   <= '0;
            r_depth    <= 2'd0;
            r_ovf      <= 1'b0;
            r_unf      <= 1'b0;
        end else begin
            r_pc       <= w_pc_nxt;
            r_ir       <= w_ir_nxt;
            r_ir_valid <= w_ir_valid_nxt;
            r_ir_pc    <= w_ir_pc_nxt;
            r_stack0   <= w_stack0_nxt;
            r_stack1   <= w_stack1_nxt;
            r_depth    <= w_depth_nxt;
            r_ovf      <= w_ovf_nxt;
            r_unf      <= w_unf_nxt;
        end
    end

    assign o_ir        = r_ir;
    assign o_ir_valid  = r_ir_valid;
    assign o_ir_pc     = r_ir_pc;
    assign o_stack_ovf = r_ovf;
    assign o_stack_unf = r_unf;

endmodule

// File: tb/tb_pic_fetch.sv
// Directed, table-driven bench for pic_fetch with a behavioural program ROM.
module tb_pic_fetch;

    logic        clk;
    logic        rst;
    logic [8:0]  rom_addr;
    logic [11:0] rom_data;
    logic        stall, jump_en, call_en, ret_en, skip;
    logic [8:0]  jump_addr;
    logic [11:0] ir;
    logic        ir_valid;
    logic [8:0]  ir_pc;
    logic        stack_ovf, stack_unf;

    logic [11:0] rom [512];

    int n_pass = 0;
    int n_tot  = 0;

    typedef struct {
        logic        stall, ret, call, jump, skip;
        logic [8:0]  jaddr;
        logic [8:0]  e_addr;
        logic [11:0] e_ir;
        logic        e_v;
        logic [8:0]  e_irpc;
        logic        e_ovf, e_unf;
    } vec_t;

    vec_t tbl [35];

    pic_fetch dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .o_rom_addr  (rom_addr),
        .i_rom_data  (rom_data),
        .i_stall     (stall),
        .i_jump_en   (jump_en),
        .i_call_en   (call_en),
        .i_ret_en    (ret_en),
        .i_skip      (skip),
        .i_jump_addr (jump_addr),
        .o_ir        (ir),
        .o_ir_valid  (ir_valid),
        .o_ir_pc     (ir_pc),
        .o_stack_ovf (stack_ovf),
        .o_stack_unf (stack_unf)
    );

    assign rom_data = rom[rom_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic s, r, c, j, k, input logic [8:0] ja, ea,
                                input logic [11:0] ei, input logic ev, input logic [8:0] ep,
                                input logic eo, eu);
        vec_t t;
        t.stall = s; t.ret = r; t.call = c; t.jump = j; t.skip = k; t.jaddr = ja;
        t.e_addr = ea; t.e_ir = ei; t.e_v = ev; t.e_irpc = ep; t.e_ovf = eo; t.e_unf = eu;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act !== exp) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        else n_pass++;
    endtask

    task automatic chk_all(input string tag, input logic [8:0] ea, input logic [11:0] ei,
                           input logic ev, input logic [8:0] ep, input logic eo, eu);
        chk({tag, ".rom_addr"}, 32'(rom_addr), 32'(ea));
        chk({tag, ".ir"},       32'(ir),       32'(ei));
        chk({tag, ".ir_valid"}, 32'(ir_valid), 32'(ev));
        chk({tag, ".ir_pc"},    32'(ir_pc),    32'(ep));
        chk({tag, ".ovf"},      32'(stack_ovf), 32'(eo));
        chk({tag, ".unf"},      32'(stack_unf), 32'(eu));
    endtask

    task automatic drive(input logic s, r, c, j, k, input logic [8:0] ja);
        stall = s; ret_en = r; call_en = c; jump_en = j; skip = k; jump_addr = ja;
    endtask

    task automatic apply(input int idx);
        vec_t t;
        t = tbl[idx];
        drive(t.stall, t.ret, t.call, t.jump, t.skip, t.jaddr);
        @(posedge clk);
        #1;
        chk_all($sformatf("vec%0d", idx), t.e_addr, t.e_ir, t.e_v, t.e_irpc, t.e_ovf, t.e_unf);
    endtask

    initial begin
        for (int a = 0; a < 512; a++) rom[a] = {3'b101, 9'(a)};
        rom[0] = 12'hC09; rom[1] = 12'h028; rom[18] = 12'h000;
        rom[25] = 12'h200; rom[29] = 12'h080; rom[511] = 12'h000;

        // Reset release: sequential fetch from 0.
        tbl[0]  = mk(0,0,0,0,0, 9'h000, 9'h001, 12'hC09, 1, 9'h000, 0, 0);
        tbl[1]  = mk(0,0,0,0,0, 9'h000, 9'h002, 12'h028, 1, 9'h001, 0, 0);
        tbl[2]  = mk(0,0,0,0,0, 9'h000, 9'h003, 12'hA02, 1, 9'h002, 0, 0);
        // From pc=20: jump, call/skip/ret.
        tbl[3]  = mk(0,0,0,1,0, 9'h019, 9'h019, 12'h000, 0, 9'h013, 0, 0);
        tbl[4]  = mk(0,0,0,0,0, 9'h000, 9'h01A, 12'h200, 1, 9'h019, 0, 0);
        tbl[5]  = mk(0,0,0,0,0, 9'h000, 9'h01B, 12'hA1A, 1, 9'h01A, 0, 0);
        tbl[6]  = mk(0,0,0,0,0, 9'h000, 9'h01C, 12'hA1B, 1, 9'h01B, 0, 0);
        tbl[7]  = mk(0,0,0,0,0, 9'h000, 9'h01D, 12'hA1C, 1, 9'h01C, 0, 0);
        tbl[8]  = mk(0,0,1,0,0, 9'h012, 9'h012, 12'h000, 0, 9'h01C, 0, 0);
        tbl[9]  = mk(0,0,0,0,0, 9'h000, 9'h013, 12'h000, 1, 9'h012, 0, 0);
        tbl[10] = mk(0,0,0,0,1, 9'h000, 9'h014, 12'h000, 0, 9'h013, 0, 0);
        tbl[11] = mk(0,0,0,0,0, 9'h000, 9'h015, 12'hA14, 1, 9'h014, 0, 0);
        tbl[12] = mk(0,1,0,0,0, 9'h000, 9'h01D, 12'h000, 0, 9'h014, 0, 0);
        tbl[13] = mk(0,0,0,0,0, 9'h000, 9'h01E, 12'h080, 1, 9'h01D, 0, 0);
        // Three calls, overflow, then three returns with underflow.
        tbl[14] = mk(0,0,1,0,0, 9'h040, 9'h040, 12'h000, 0, 9'h01D, 0, 0);
        tbl[15] = mk(0,0,1,0,0, 9'h050, 9'h050, 12'h000, 0, 9'h01D, 0, 0);
        tbl[16] = mk(0,0,0,0,0, 9'h000, 9'h051, 12'hA50, 1, 9'h050, 0, 0);
        tbl[17] = mk(0,0,1,0,0, 9'h060, 9'h060, 12'h000, 0, 9'h050, 1, 0);
        tbl[18] = mk(0,1,0,0,0, 9'h000, 9'h051, 12'h000, 0, 9'h050, 1, 0);
        tbl[19] = mk(0,0,0,0,0, 9'h000, 9'h052, 12'hA51, 1, 9'h051, 1, 0);
        tbl[20] = mk(0,1,0,0,0, 9'h000, 9'h040, 12'h000, 0, 9'h051, 1, 0);
        tbl[21] = mk(0,1,0,0,0, 9'h000, 9'h040, 12'h000, 0, 9'h051, 1, 1);
        tbl[22] = mk(0,0,0,0,0, 9'h000, 9'h041, 12'hA40, 1, 9'h040, 1, 1);
        // Stall with a pending jump, then release.
        for (int i = 23; i < 27; i++)
            tbl[i] = mk(1,0,0,1,0, 9'h1FF, 9'h041, 12'hA40, 1, 9'h040, 1, 1);
        tbl[27] = mk(0,0,0,1,0, 9'h1FF, 9'h1FF, 12'h000, 0, 9'h040, 1, 1);
        tbl[28] = mk(0,0,0,0,0, 9'h000, 9'h000, 12'h000, 1, 9'h1FF, 1, 1);
        tbl[29] = mk(0,0,0,0,0, 9'h000, 9'h001, 12'hC09, 1, 9'h000, 1, 1);
        // Priority between simultaneous commands.
        tbl[30] = mk(0,0,1,1,0, 9'h030, 9'h030, 12'h000, 0, 9'h000, 1, 1);
        tbl[31] = mk(0,1,1,1,1, 9'h070, 9'h001, 12'h000, 0, 9'h000, 1, 1);
        tbl[32] = mk(0,0,0,0,1, 9'h000, 9'h002, 12'h000, 0, 9'h001, 1, 1);
        tbl[33] = mk(0,0,0,1,1, 9'h033, 9'h033, 12'h000, 0, 9'h001, 1, 1);
        tbl[34] = mk(0,0,0,0,0, 9'h000, 9'h034, 12'hA33, 1, 9'h033, 1, 1);

        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 9'h000);
        repeat (2) @(posedge clk);
        #1;
        chk_all("reset", 9'h000, 12'h000, 0, 9'h000, 0, 0);
        rst = 1'b0;

        for (int i = 0; i < 3; i++) apply(i);

        // Sequential run-up from pc=3 to pc=20.
        for (int a = 3; a < 20; a++) begin
            drive(0, 0, 0, 0, 0, 9'h000);
            @(posedge clk);
            #1;
            chk_all($sformatf("run%0d", a), 9'(a + 1), rom[a], 1, 9'(a), 0, 0);
        end

        for (int i = 3; i < 35; i++) apply(i);

        // Reset asserted between edges while a call is pending.
        drive(0, 0, 1, 0, 0, 9'h055);
        #2 rst = 1'b1;
        #1;
        chk_all("rst_async", 9'h000, 12'h000, 0, 9'h000, 0, 0);
        @(posedge clk);
        #1;
        chk_all("rst_hold", 9'h000, 12'h000, 0, 9'h000, 0, 0);
        drive(0, 0, 0, 0, 0, 9'h000);
        rst = 1'b0;
        // Empty stack: a return underflows and reloads the cleared stack0.
        drive(0, 1, 0, 0, 0, 9'h000);
        @(posedge clk);
        #1;
        chk_all("rst_ret", 9'h000, 12'h000, 0, 9'h000, 0, 1);
        drive(0, 0, 0, 0, 0, 9'h000);
        @(posedge clk);
        #1;
        chk_all("rst_seq", 9'h001, 12'hC09, 1, 9'h000, 0, 1);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
